// File: rtl/calc_arbiter.sv
// calc_arbiter: two-requester arbiter in front of a shared calculator datapath.
// Optional opcode check enabled by defining CALC_ARB_OPCHK_EN.
module calc_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [4:0]  req0_op,
  input  logic [4:0]  req1_op,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  output logic [15:0] alu_inp1,
  output logic [15:0] alu_inp2,
  output logic [4:0]  alu_select,
  input  logic [15:0] alu_a,
  input  logic [15:0] alu_b,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [15:0] resp_a,
  output logic [15:0] resp_b,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        own_q, own_d;
  logic [15:0] inp1_q, inp1_d;
  logic [15:0] inp2_q, inp2_d;
  logic [4:0]  sel_q, sel_d;
  logic        rvalid_q, rvalid_d;
  logic        rid_q, rid_d;
  logic [15:0] ra_q, ra_d;
  logic [15:0] rb_q, rb_d;
  logic        rerr_q, rerr_d;

  logic        gnt0, gnt1, hs, win;
  logic [4:0]  win_op;
  logic [15:0] win_x, win_y;
  logic        bad_op;

  // Grant: single valid wins; on a tie the requester not granted last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign hs     = gnt0 | gnt1;
  assign win    = gnt1;
  assign win_op = win ? req1_op : req0_op;
  assign win_x  = win ? req1_x  : req0_x;
  assign win_y  = win ? req1_y  : req0_y;

`ifdef CALC_ARB_OPCHK_EN
  assign bad_op = (win_op > 5'd23);
`else
  assign bad_op = 1'b0;
`endif

  // Next-state and datapath load/capture decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    own_d    = own_q;
    inp1_d   = inp1_q;
    inp2_d   = inp2_q;
    sel_d    = sel_q;
    rvalid_d = 1'b0;
    rid_d    = rid_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rerr_d   = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          last_d = win;
          if (bad_op) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rid_d    = win;
            ra_d     = 16'h0000;
            rb_d     = 16'h0000;
            rerr_d   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd0;
            own_d   = win;
            inp1_d  = win_x;
            inp2_d  = win_y;
            sel_d   = win_op;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rid_d    = own_q;
          ra_d     = alu_a;
          rb_d     = alu_b;
          rerr_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      own_q    <= 1'b0;
      inp1_q   <= 16'h0000;
      inp2_q   <= 16'h0000;
      sel_q    <= 5'd0;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
      ra_q     <= 16'h0000;
      rb_q     <= 16'h0000;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      own_q    <= own_d;
      inp1_q   <= inp1_d;
      inp2_q   <= inp2_d;
      sel_q    <= sel_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rerr_q   <= rerr_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign alu_inp1   = inp1_q;
  assign alu_inp2   = inp2_q;
  assign alu_select = sel_q;
  assign resp_valid = rvalid_q;
  assign resp_id    = rid_q;
  assign resp_a     = ra_q;
  assign resp_b     = rb_q;

`ifdef CALC_ARB_OPCHK_EN
  assign resp_err = rerr_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: directed stimulus with a response scoreboard.
// Responses are checked by a monitor against a queue of expected results.
module tb_calc_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic [15:0] alu_inp1, alu_inp2;
  logic [4:0]  alu_select;
  logic [15:0] alu_a, alu_b;
  logic        resp_valid, resp_id, resp_err;
  logic [15:0] resp_a, resp_b;

  logic        ovr_en = 1'b0;
  logic [15:0] ovr_a = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        err;
  } exp_t;

  exp_t q[$];

  calc_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_x(req1_x), .req1_y(req1_y),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
    .alu_select(alu_select),
    .alu_a(alu_a), .alu_b(alu_b),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_a(resp_a), .resp_b(resp_b),
    .resp_err(resp_err)
  );

  // ALU stub: a = x + y, b = x - y; a can be overridden to model glitches.
  assign alu_a = ovr_en ? ovr_a : alu_inp1 + alu_inp2;
  assign alu_b = alu_inp1 - alu_inp2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic id, input logic [15:0] a,
                      input logic [15:0] b, input logic err);
    exp_t e;
    e.cyc = c; e.id = id; e.a = a; e.b = b; e.err = err;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ovr_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_ready(input string name, input logic r0, input logic r1);
    @(negedge clk);
    chk({name, "_rdy0"}, 32'(req0_ready), 32'(r0));
    chk({name, "_rdy1"}, 32'(req1_ready), 32'(r1));
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_a", 32'(resp_a), 32'(e.a));
        chk("resp_b", 32'(resp_b), 32'(e.b));
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  initial begin
    int t0;
    int t1;
    int seen;

    // Reset state, with both requesters valid during reset.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_inp1", 32'(alu_inp1), 32'd0);
    chk("rst_sel", 32'(alu_select), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_ra", 32'(resp_a), 32'd0);
    do_reset();

    // Basic single request.
    t0 = cyc;
    req0_op = 5'd3; req0_x = 16'd25; req0_y = 16'd6; req0_valid = 1'b1;
    push(t0 + 3, 1'b0, 16'h001F, 16'h0013, 1'b0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("basic_inp1", 32'(alu_inp1), 32'd25);
    chk("basic_inp2", 32'(alu_inp2), 32'd6);
    chk("basic_sel", 32'(alu_select), 32'd3);
    tick(); tick(); tick();
    @(negedge clk);
    chk("basic_hold_inp1", 32'(alu_inp1), 32'd25);
    chk("basic_hold_rid", 32'(resp_id), 32'd0);
    chk("basic_hold_ra", 32'(resp_a), 32'h1F);

    // Both valid and held: round-robin req0, req1, req0.
    do_reset();
    t0 = cyc;
    req0_op = 5'd1; req0_x = 16'd10;  req0_y = 16'd3;
    req1_op = 5'd2; req1_x = 16'd100; req1_y = 16'd1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    push(t0 + 3,  1'b0, 16'd13,  16'd7,  1'b0);
    push(t0 + 7,  1'b1, 16'd101, 16'd99, 1'b0);
    push(t0 + 11, 1'b0, 16'd13,  16'd7,  1'b0);
    chk_ready("rr_c0", 1'b1, 1'b0);
    tick();
    chk_ready("rr_c1", 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_ready("rr_c4", 1'b0, 1'b1);
    tick(); tick(); tick(); tick();
    chk_ready("rr_c8", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) tick();

    // req1 arrives while busy; waits, then issued with its operands.
    do_reset();
    t0 = cyc;
    req0_op = 5'd0; req0_x = 16'd7; req0_y = 16'd2; req0_valid = 1'b1;
    push(t0 + 3, 1'b0, 16'd9,  16'd5,  1'b0);
    push(t0 + 7, 1'b1, 16'd48, 16'd32, 1'b0);
    tick();
    req0_valid = 1'b0;
    req1_op = 5'd0; req1_x = 16'd40; req1_y = 16'd8; req1_valid = 1'b1;
    chk_ready("busy_c1", 1'b0, 1'b0);
    tick(); tick();
    chk_ready("busy_c3", 1'b0, 1'b0);
    tick();
    chk_ready("busy_c4", 1'b0, 1'b1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("busy_inp1", 32'(alu_inp1), 32'd40);
    chk("busy_inp2", 32'(alu_inp2), 32'd8);
    repeat (3) tick();

    // ALU result changes while settling; only the capture edge counts.
    do_reset();
    t0 = cyc;
    req0_op = 5'd4; req0_x = 16'd2; req0_y = 16'd3; req0_valid = 1'b1;
    push(t0 + 3, 1'b0, 16'h0005, 16'hFFFF, 1'b0);
    tick();
    req0_valid = 1'b0;
    ovr_en = 1'b1;
    ovr_a = 16'hFFFF;
    tick();
    ovr_a = 16'h0005;
    tick();
    ovr_a = 16'h1234;
    tick();
    @(negedge clk);
    chk("glitch_hold_ra", 32'(resp_a), 32'h0005);
    ovr_en = 1'b0;

    // Reset mid-operation discards it.
    do_reset();
    t0 = cyc;
    req0_op = 5'd1; req0_x = 16'd1; req0_y = 16'd1; req0_valid = 1'b1;
    tick();
    rst = 1'b1;
    req0_valid = 1'b0;
    #1;
    chk("midrst_inp1", 32'(alu_inp1), 32'd0);
    chk("midrst_inp2", 32'(alu_inp2), 32'd0);
    chk("midrst_sel", 32'(alu_select), 32'd0);
    chk("midrst_rv", 32'(resp_valid), 32'd0);
    chk("midrst_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("midrst_no_resp", 32'(seen), 32'd0);
    tick();

    // Opcode boundary: 23 is always forwarded; 30 depends on the build.
    do_reset();
    t0 = cyc;
    req0_op = 5'd23; req0_x = 16'd9; req0_y = 16'd4; req0_valid = 1'b1;
    push(t0 + 3, 1'b0, 16'd13, 16'd5, 1'b0);
    tick();
    req0_valid = 1'b0;
    tick(); tick(); tick();
    t1 = cyc;
    req1_op = 5'd30; req1_x = 16'd50; req1_y = 16'd5; req1_valid = 1'b1;
`ifdef CALC_ARB_OPCHK_EN
    push(t1 + 1, 1'b1, 16'd0, 16'd0, 1'b1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("opchk_sel", 32'(alu_select), 32'd23);
    chk("opchk_inp1", 32'(alu_inp1), 32'd9);
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("opchk_ptr_rdy0", 32'(req0_ready), 32'd1);
    chk("opchk_ptr_rdy1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
`else
    push(t1 + 3, 1'b1, 16'd55, 16'd45, 1'b0);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("op30_sel", 32'(alu_select), 32'd30);
    tick(); tick(); tick();
`endif
    repeat (3) tick();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, sets cycles the ALU outputs are allowed to settle before capture; legal range 1-15.
REQ-002 Port clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port rst  in  1  reset, asynchronous, active-high.
REQ-004 Ports req0_valid, req1_valid  in  1 each  requester N presents an operation.
REQ-005 Ports req0_ready, req1_ready  out  1 each  operation accepted when valid and ready are both high on a rising edge.
REQ-006 Ports req0_op, req1_op  in  5 each  opcode forwarded to the ALU select.
REQ-007 Ports req0_x, req0_y, req1_x, req1_y  in  16 each  operands.
REQ-008 Ports alu_inp1, alu_inp2  out  16 each, and alu_select  out  5  registered drive to the shared calculator datapath.
REQ-009 Ports alu_a, alu_b  in  16 each  calculator results.
REQ-010 Port resp_valid  out  1  one-cycle completion pulse.
REQ-011 Port resp_id  out  1  requester that owns the response.
REQ-012 Ports resp_a, resp_b  out  16 each  captured results; resp_err  out  1  opcode rejected.

Function
REQ-013 FSM states IDLE, WAIT, RESP; IDLE -> WAIT on handshake, WAIT -> RESP after SETTLE_CYCLES cycles, RESP -> IDLE after one cycle.
REQ-014 reqN_ready is high only in IDLE, only for the arbitration winner, and only while reqN_valid is high; never both high.
REQ-015 Arbitration: one valid request wins; with both valid, the requester not granted last wins; last-grant pointer updates only on handshake.
REQ-016 At the handshake edge, alu_inp1/alu_inp2/alu_select load the winner's x/y/op and the winner's index is stored for resp_id.
REQ-017 alu_* outputs hold the last issued values until the next handshake, and never return to zero after completion.
REQ-018 At the edge ending the last WAIT cycle, alu_a/alu_b are captured into resp_a/resp_b.
REQ-019 Timing: handshake in cycle c0, WAIT in c1..cS, resp_valid=1 in c(S+1) only; next handshake earliest in c(S+2).
REQ-020 resp_a/resp_b/resp_id/resp_err hold their values after RESP until the next capture.
REQ-021 A request presented while the block is not in IDLE gets ready low and waits; the requester holds valid and data stable until handshake.
REQ-022 A requester may drop valid without a handshake; no grant or pointer change results.
REQ-023 A change on alu_a/alu_b outside the capture edge has no effect on resp_a/resp_b.

Reset
REQ-024 On rst, asynchronously: state=IDLE, alu_*=0, resp_*=0, resp_valid=0, ready outputs=0, last-grant pointer=1 (req0 wins the first tie).
REQ-025 rst asserted mid-operation discards the in-flight operation; no resp_valid is produced after rst deasserts.

Configuration
REQ-026 Macro CALC_ARB_OPCHK_EN defined: an accepted op greater than 5'd23 skips WAIT, goes directly to RESP with resp_err=1 and resp_a=resp_b=0, leaves alu_* unchanged, and still updates the last-grant pointer.
REQ-027 Macro CALC_ARB_OPCHK_EN undefined: every opcode is forwarded normally, and the resp_err port stays present, tied to 0.

Verification
REQ-028 After reset, req0 op=3 x=25 y=6, ALU stub alu_a=16'h001F alu_b=16'h0013 -> alu_inp1=25 alu_inp2=6 alu_select=3 from c1; resp_valid in c3 only; resp_id=0; resp_a=16'h001F; resp_b=16'h0013.
REQ-029 Both requests valid from the first IDLE cycle after reset and held -> grant order req0, req1, req0; handshakes 4 cycles apart with SETTLE_CYCLES=2.
REQ-030 req1 valid while busy serving req0 -> req1_ready low until IDLE; then accepted with x/y unchanged.
REQ-031 Change alu_a to 16'hFFFF in c1, then to 16'h0005 in c2 -> resp_a=16'h0005.
REQ-032 Assert rst in c1 of an operation -> all outputs 0 immediately; resp_valid stays 0 for the following 10 cycles with no request.
REQ-033 CALC_ARB_OPCHK_EN defined, op=5'd30 -> resp_valid in c1, resp_err=1, resp_a=0, alu_select unchanged; undefined -> resp in c3 with resp_err=0.
